// File: rtl/asic_wram_arb.sv
// asic_wram_arb
//   Word-RAM port arbiter downstream of the stamp rotation ASIC. Merges the
//   ASIC's held-level WRAM requests with sub-CPU word accesses onto a single
//   2M word-RAM port, returns registered read data to each requester and
//   produces the ownership flag the ASIC sees.
//
// Ports
//   clk_asic, rst           : single clock, synchronous active-high reset
//   wram_mode, wram_for_sub : WRAM mode (1 = 1M) and 2M ownership (1 = sub side)
//   wram_*_asic             : ASIC address/data/level strobes, registered read data
//   asic_wram_for_sub       : ownership flag as presented to the ASIC
//   sub_*                   : sub-CPU level request, byte strobes, read data, ack pulse
//   mem_*                   : word-RAM port (registered address/data/strobes)
//
// MEM_LAT (1..7): cycles from address/strobe drive until mem_do is valid.
module asic_wram_arb #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk_asic,
    input  logic        rst,
    input  logic        wram_mode,
    input  logic        wram_for_sub,
    input  logic [16:0] wram_addr_asic,
    input  logic [15:0] wram_din_asic,
    input  logic        wram_we_asic,
    input  logic        wram_oe_asic,
    output logic [15:0] wram_dout_asic,
    output logic        asic_wram_for_sub,
    input  logic        sub_req,
    input  logic [16:0] sub_addr,
    input  logic [15:0] sub_di,
    input  logic        sub_we_lo,
    input  logic        sub_we_hi,
    output logic [15:0] sub_do,
    output logic        sub_ack,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_di,
    input  logic [15:0] mem_do,
    output logic        mem_oe,
    output logic        mem_we_lo,
    output logic        mem_we_hi
);

    typedef enum logic [1:0] {IDLE, SUB_ACC, ASIC_ACC} state_t;
    typedef enum logic {OWN_ASIC, OWN_SUB} owner_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t     state;
    owner_t     last_owner;
    logic [2:0] lat_ctr;

    logic asic_ok, asic_rq, sub_pend, sub_go, lat_done;

    assign asic_ok  = wram_for_sub & ~wram_mode;
    assign asic_rq  = asic_ok & (wram_oe_asic | wram_we_asic);
    // A request seen alongside its own ack is the tail of the previous
    // access, not a new one.
    assign sub_pend = sub_req & ~sub_ack;
    // With both sides pending, the side that did not go last wins.
    assign sub_go   = sub_pend & (~asic_rq | (last_owner == OWN_ASIC));
    assign lat_done = (lat_ctr == LAT_LAST);

    always_ff @(posedge clk_asic) begin
        if (rst) begin
            state             <= IDLE;
            last_owner        <= OWN_ASIC;
            lat_ctr           <= 3'd0;
            wram_dout_asic    <= 16'h0000;
            sub_do            <= 16'h0000;
            sub_ack           <= 1'b0;
            mem_addr          <= 17'h00000;
            mem_di            <= 16'h0000;
            mem_oe            <= 1'b0;
            mem_we_lo         <= 1'b0;
            mem_we_hi         <= 1'b0;
            asic_wram_for_sub <= 1'b0;
        end else begin
            sub_ack           <= 1'b0;
            // ASIC sees the RAM as intercepted while the sub is pending or served.
            asic_wram_for_sub <= asic_ok & (state != SUB_ACC) & ~sub_pend;

            case (state)
                IDLE: begin
                    if (sub_go) begin
                        state     <= SUB_ACC;
                        lat_ctr   <= 3'd0;
                        mem_addr  <= sub_addr;
                        mem_di    <= sub_di;
                        mem_oe    <= ~(sub_we_lo | sub_we_hi);
                        mem_we_lo <= sub_we_lo;
                        mem_we_hi <= sub_we_hi;
                    end else if (asic_rq) begin
                        // Write wins over read when both levels are high.
                        state     <= ASIC_ACC;
                        lat_ctr   <= 3'd0;
                        mem_addr  <= wram_addr_asic;
                        mem_di    <= wram_din_asic;
                        mem_oe    <= ~wram_we_asic;
                        mem_we_lo <= wram_we_asic;
                        mem_we_hi <= wram_we_asic;
                    end
                end

                SUB_ACC: begin
                    lat_ctr <= lat_ctr + 3'd1;
                    if (lat_done) begin
                        if (mem_oe) sub_do <= mem_do;
                        sub_ack    <= 1'b1;
                        mem_oe     <= 1'b0;
                        mem_we_lo  <= 1'b0;
                        mem_we_hi  <= 1'b0;
                        last_owner <= OWN_SUB;
                        state      <= IDLE;
                    end
                end

                ASIC_ACC: begin
                    lat_ctr <= lat_ctr + 3'd1;
                    if (!asic_ok) begin
                        // Ownership pulled away: abandon without returning data.
                        mem_oe    <= 1'b0;
                        mem_we_lo <= 1'b0;
                        mem_we_hi <= 1'b0;
                        state     <= IDLE;
                    end else if (lat_done) begin
                        if (mem_oe) wram_dout_asic <= mem_do;
                        mem_oe     <= 1'b0;
                        mem_we_lo  <= 1'b0;
                        mem_we_hi  <= 1'b0;
                        last_owner <= OWN_ASIC;
                        state      <= IDLE;
                    end
                end

                default: begin
                    mem_oe    <= 1'b0;
                    mem_we_lo <= 1'b0;
                    mem_we_hi <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asic_wram_arb.sv
module tb_asic_wram_arb;

    localparam int MEM_LAT = 2;

    logic        clk_asic = 1'b0;
    logic        rst;
    logic        wram_mode, wram_for_sub;
    logic [16:0] wram_addr_asic;
    logic [15:0] wram_din_asic;
    logic        wram_we_asic, wram_oe_asic;
    logic [15:0] wram_dout_asic;
    logic        asic_wram_for_sub;
    logic        sub_req;
    logic [16:0] sub_addr;
    logic [15:0] sub_di;
    logic        sub_we_lo, sub_we_hi;
    logic [15:0] sub_do;
    logic        sub_ack;
    logic [16:0] mem_addr;
    logic [15:0] mem_di, mem_do;
    logic        mem_oe, mem_we_lo, mem_we_hi;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    logic [15:0] sb[$];
    logic [15:0] mem [0:131071];

    always #5 clk_asic = ~clk_asic;

    asic_wram_arb #(.MEM_LAT(MEM_LAT)) dut (
        .clk_asic(clk_asic), .rst(rst),
        .wram_mode(wram_mode), .wram_for_sub(wram_for_sub),
        .wram_addr_asic(wram_addr_asic), .wram_din_asic(wram_din_asic),
        .wram_we_asic(wram_we_asic), .wram_oe_asic(wram_oe_asic),
        .wram_dout_asic(wram_dout_asic), .asic_wram_for_sub(asic_wram_for_sub),
        .sub_req(sub_req), .sub_addr(sub_addr), .sub_di(sub_di),
        .sub_we_lo(sub_we_lo), .sub_we_hi(sub_we_hi),
        .sub_do(sub_do), .sub_ack(sub_ack),
        .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
        .mem_oe(mem_oe), .mem_we_lo(mem_we_lo), .mem_we_hi(mem_we_hi)
    );

    // Word RAM model: preloaded while in reset, byte writes on strobes.
    assign mem_do = mem[mem_addr];
    always @(posedge clk_asic) begin
        if (rst) begin
            mem[17'h00100] <= 16'hA5C3;
            mem[17'h00040] <= 16'hBEEF;
            mem[17'h00300] <= 16'h1357;
            mem[17'h00200] <= 16'h0000;
            mem[17'h1FFFF] <= 16'h0000;
        end else begin
            if (mem_we_lo) mem[mem_addr][7:0]  <= mem_di[7:0];
            if (mem_we_hi) mem[mem_addr][15:8] <= mem_di[15:8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every sub ack pops the sub_do value queued at request time.
    always @(negedge clk_asic) begin
        if (!rst && sub_ack === 1'b1) begin
            ack_cnt++;
            check("sb_ack_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) check("sb_sub_do", {16'd0, sub_do}, {16'd0, sb.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_asic);
            #1;
        end
    endtask

    function automatic logic strobes();
        return mem_oe | mem_we_lo | mem_we_hi;
    endfunction

    initial begin
        rst = 1'b1;
        wram_mode = 1'b0; wram_for_sub = 1'b0;
        wram_addr_asic = '0; wram_din_asic = '0;
        wram_we_asic = 1'b0; wram_oe_asic = 1'b0;
        sub_req = 1'b0; sub_addr = '0; sub_di = '0;
        sub_we_lo = 1'b0; sub_we_hi = 1'b0;

        // Reset state
        tick(2);
        check("rst_strobes", {31'd0, strobes()}, 0);
        check("rst_mem_addr", {15'd0, mem_addr}, 0);
        check("rst_mem_di", {16'd0, mem_di}, 0);
        check("rst_sub_do", {16'd0, sub_do}, 0);
        check("rst_sub_ack", {31'd0, sub_ack}, 0);
        check("rst_dout_asic", {16'd0, wram_dout_asic}, 0);
        check("rst_for_sub", {31'd0, asic_wram_for_sub}, 0);
        rst = 1'b0;
        tick(2);

        // Sub read: request at cycle r, strobes r+1..r+MEM_LAT, ack at r+MEM_LAT+1
        sub_req = 1'b1; sub_addr = 17'h00100;
        sb.push_back(16'hA5C3);
        tick(1);
        check("rd_oe_c1", {31'd0, mem_oe}, 1);
        check("rd_addr", {15'd0, mem_addr}, 32'h00100);
        check("rd_we", {30'd0, mem_we_hi, mem_we_lo}, 0);
        tick(1);
        check("rd_oe_c2", {31'd0, mem_oe}, 1);
        check("rd_ack_early", {31'd0, sub_ack}, 0);
        tick(1);
        check("rd_ack", {31'd0, sub_ack}, 1);
        check("rd_sub_do", {16'd0, sub_do}, 32'hA5C3);
        check("rd_oe_done", {31'd0, mem_oe}, 0);
        sub_req = 1'b0;
        tick(1);
        check("rd_ack_pulse", {31'd0, sub_ack}, 0);

        // Sub high-byte write, request held through the ack cycle
        sub_req = 1'b1; sub_addr = 17'h1FFFF; sub_di = 16'h1234;
        sub_we_hi = 1'b1; sub_we_lo = 1'b0;
        sb.push_back(16'hA5C3);
        tick(1);
        check("wr_we_hi", {31'd0, mem_we_hi}, 1);
        check("wr_we_lo", {31'd0, mem_we_lo}, 0);
        check("wr_oe", {31'd0, mem_oe}, 0);
        check("wr_di", {16'd0, mem_di}, 32'h1234);
        check("wr_addr", {15'd0, mem_addr}, 32'h1FFFF);
        tick(2);
        check("wr_ack", {31'd0, sub_ack}, 1);
        tick(1);
        check("wr_no_reissue", {31'd0, strobes()}, 0);
        check("wr_ack_pulse", {31'd0, sub_ack}, 0);
        sub_req = 1'b0; sub_we_hi = 1'b0;
        tick(2);
        check("wr_still_idle", {31'd0, strobes()}, 0);
        check("wr_ack_count", ack_cnt, 2);
        check("wr_mem", {16'd0, mem[17'h1FFFF]}, 32'h1200);

        // ASIC read aborted by ownership loss
        wram_for_sub = 1'b1; wram_addr_asic = 17'h00040; wram_oe_asic = 1'b1;
        tick(1);
        check("ab_oe", {31'd0, mem_oe}, 1);
        check("ab_addr", {15'd0, mem_addr}, 32'h00040);
        wram_for_sub = 1'b0;
        tick(1);
        check("ab_oe_drop", {31'd0, mem_oe}, 0);
        check("ab_dout", {16'd0, wram_dout_asic}, 0);
        check("ab_for_sub", {31'd0, asic_wram_for_sub}, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("ab_no_access", {31'd0, strobes()}, 0);
        end

        // ASIC read completing normally
        wram_for_sub = 1'b1;
        tick(MEM_LAT + 1);
        check("ard_dout", {16'd0, wram_dout_asic}, 32'hBEEF);
        check("ard_for_sub", {31'd0, asic_wram_for_sub}, 1);
        check("ard_idle", {31'd0, strobes()}, 0);
        wram_oe_asic = 1'b0;

        // Contention: sub read vs ASIC write, both held; grants alternate
        sub_req = 1'b1; sub_addr = 17'h00300;
        wram_we_asic = 1'b1; wram_addr_asic = 17'h00200; wram_din_asic = 16'hF0F0;
        sb.push_back(16'h1357);
        sb.push_back(16'h1357);
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                tick(1);
                if (g % 2 == 0) begin
                    check("ct_sub_addr", {15'd0, mem_addr}, 32'h00300);
                    check("ct_sub_oe", {29'd0, mem_oe, mem_we_hi, mem_we_lo}, 32'h4);
                    check("ct_for_sub_sub", {31'd0, asic_wram_for_sub}, 0);
                end else begin
                    check("ct_asic_addr", {15'd0, mem_addr}, 32'h00200);
                    check("ct_asic_we", {29'd0, mem_oe, mem_we_hi, mem_we_lo}, 32'h3);
                    check("ct_asic_di", {16'd0, mem_di}, 32'hF0F0);
                end
            end
            tick(1);
            check("ct_idle_gap", {31'd0, strobes()}, 0);
            check("ct_for_sub_gap", {31'd0, asic_wram_for_sub}, 0);
            check("ct_ack", {31'd0, sub_ack}, (g % 2 == 0) ? 32'd1 : 32'd0);
        end
        sub_req = 1'b0; wram_we_asic = 1'b0;
        check("ct_mem_wr", {16'd0, mem[17'h00200]}, 32'hF0F0);
        check("ct_dout_hold", {16'd0, wram_dout_asic}, 32'hBEEF);

        // 1M mode: ASIC locked out, sub still served
        wram_mode = 1'b1; wram_oe_asic = 1'b1; wram_we_asic = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("m1_no_strobe", {31'd0, strobes()}, 0);
            check("m1_for_sub", {31'd0, asic_wram_for_sub}, 0);
        end
        sub_req = 1'b1; sub_addr = 17'h00100;
        sb.push_back(16'hA5C3);
        tick(MEM_LAT + 1);
        check("m1_sub_ack", {31'd0, sub_ack}, 1);
        sub_req = 1'b0;
        tick(2);
        check("m1_after", {31'd0, strobes()}, 0);
        wram_oe_asic = 1'b0; wram_we_asic = 1'b0; wram_mode = 1'b0;

        // Reset in the middle of a sub access
        sub_req = 1'b1; sub_addr = 17'h00300;
        tick(1);
        check("rm_oe", {31'd0, mem_oe}, 1);
        rst = 1'b1; sub_req = 1'b0;
        tick(1);
        check("rm_strobes", {31'd0, strobes()}, 0);
        check("rm_sub_do", {16'd0, sub_do}, 0);
        check("rm_sub_ack", {31'd0, sub_ack}, 0);
        check("rm_dout", {16'd0, wram_dout_asic}, 0);
        check("rm_mem_addr", {15'd0, mem_addr}, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rm_no_ack", {31'd0, sub_ack}, 0);
        end
        // Back in IDLE: a fresh sub read has the nominal latency
        sub_req = 1'b1; sub_addr = 17'h00100;
        sb.push_back(16'hA5C3);
        tick(MEM_LAT);
        check("rm2_no_ack_yet", {31'd0, sub_ack}, 0);
        tick(1);
        check("rm2_ack", {31'd0, sub_ack}, 1);
        check("rm2_sub_do", {16'd0, sub_do}, 32'hA5C3);
        sub_req = 1'b0;
        tick(2);

        check("sb_drained", sb.size(), 0);
        check("total_acks", ack_cnt, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
